// File: rtl/arm7_pkg.sv
// rtl/arm7_pkg.sv - shared constants and types for the banked ARM7 register file
// Contents: processor mode encodings, CPSR bit positions, reset CPSR default,
// physical storage sizes and the exception-entry FSM state type.
package arm7_pkg;

    localparam logic [4:0] MODE_USR = 5'h10;
    localparam logic [4:0] MODE_FIQ = 5'h11;
    localparam logic [4:0] MODE_IRQ = 5'h12;
    localparam logic [4:0] MODE_SVC = 5'h13;
    localparam logic [4:0] MODE_ABT = 5'h17;
    localparam logic [4:0] MODE_UND = 5'h1B;
    localparam logic [4:0] MODE_SYS = 5'h1F;

    localparam int CPSR_N     = 31;
    localparam int CPSR_Z     = 30;
    localparam int CPSR_C     = 29;
    localparam int CPSR_V     = 28;
    localparam int CPSR_I     = 7;
    localparam int CPSR_F     = 6;
    localparam int CPSR_T     = 5;
    localparam int CPSR_M_MSB = 4;
    localparam int CPSR_M_LSB = 0;

    localparam logic [31:0] RESET_CPSR_DEFAULT = 32'h0000_00D3;

    // Physical layout: 0..14 user R0-R14, 15 PC, 16..22 FIQ R8-R14,
    // 23/24 IRQ, 25/26 SVC, 27/28 ABT, 29/30 UND (R13/R14 each).
    localparam int         NUM_PHYS = 31;
    localparam int         NUM_SPSR = 5;
    localparam logic [4:0] PHYS_PC  = 5'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SAVE = 2'd1,
        LINK = 2'd2
    } exc_state_e;

endpackage

// File: rtl/arm7_regfile_if.sv
// rtl/arm7_regfile_if.sv - request/response bundle between execute units and the register file
// master: execute side (drives read/write/exception requests, sees read data, pc, cpsr, busy)
// slave : register file (inverse directions)
interface arm7_regfile_if;

    logic        read_en;
    logic [3:0]  read_reg;
    logic [31:0] read_value;
    logic        write_en;
    logic [3:0]  write_reg;
    logic [31:0] write_value;
    logic        write_restore_from_SPSR;
    logic        exc_en;
    logic [4:0]  exc_mode;
    logic [31:0] exc_return;
    logic [31:0] exc_vector;
    logic [31:0] pc;
    logic [31:0] cpsr;
    logic        busy;

    modport master (
        output read_en, read_reg, write_en, write_reg, write_value,
               write_restore_from_SPSR, exc_en, exc_mode, exc_return, exc_vector,
        input  read_value, pc, cpsr, busy
    );

    modport slave (
        input  read_en, read_reg, write_en, write_reg, write_value,
               write_restore_from_SPSR, exc_en, exc_mode, exc_return, exc_vector,
        output read_value, pc, cpsr, busy
    );

endinterface

// File: rtl/arm7_reg_index.sv
// rtl/arm7_reg_index.sv - (mode, logical register) to physical storage index decode
// Ports:
//   mode_i       in  5  processor mode M[4:0]
//   idx_i        in  4  logical register 0..15
//   phys_o       out 5  physical GPR slot 0..30 (15 = PC)
//   spsr_idx_o   out 3  SPSR slot 0..4 (FIQ, IRQ, SVC, ABT, UND)
//   spsr_valid_o out 1  mode owns an SPSR
module arm7_reg_index
    import arm7_pkg::*;
(
    input  logic [4:0] mode_i,
    input  logic [3:0] idx_i,
    output logic [4:0] phys_o,
    output logic [2:0] spsr_idx_o,
    output logic       spsr_valid_o
);

    logic [4:0] idx_ext;
    assign idx_ext = {1'b0, idx_i};

    always_comb begin
        phys_o       = idx_ext;
        spsr_idx_o   = 3'd0;
        spsr_valid_o = 1'b0;
        unique case (mode_i)
            MODE_FIQ: begin
                spsr_idx_o   = 3'd0;
                spsr_valid_o = 1'b1;
                if (idx_i >= 4'd8 && idx_i != 4'd15) phys_o = idx_ext + 5'd8;
            end
            MODE_IRQ: begin
                spsr_idx_o   = 3'd1;
                spsr_valid_o = 1'b1;
                if (idx_i == 4'd13 || idx_i == 4'd14) phys_o = idx_ext + 5'd10;
            end
            MODE_SVC: begin
                spsr_idx_o   = 3'd2;
                spsr_valid_o = 1'b1;
                if (idx_i == 4'd13 || idx_i == 4'd14) phys_o = idx_ext + 5'd12;
            end
            MODE_ABT: begin
                spsr_idx_o   = 3'd3;
                spsr_valid_o = 1'b1;
                if (idx_i == 4'd13 || idx_i == 4'd14) phys_o = idx_ext + 5'd14;
            end
            MODE_UND: begin
                spsr_idx_o   = 3'd4;
                spsr_valid_o = 1'b1;
                if (idx_i == 4'd13 || idx_i == 4'd14) phys_o = idx_ext + 5'd16;
            end
            // USR, SYS and every unrecognised encoding use the user bank, no SPSR.
            MODE_USR, MODE_SYS: phys_o = idx_ext;
            default:            phys_o = idx_ext;
        endcase
    end

endmodule

// File: rtl/arm7_regfile.sv
// rtl/arm7_regfile.sv - banked ARM7 register file with exception entry sequencer
// Parameters: RESET_PC (R15 after reset), RESET_CPSR (CPSR after reset)
// Ports:
//   clk    in  1  clock
//   rst_n  in  1  asynchronous active-low reset
//   bus    slave modport of arm7_regfile_if: registered reads, single writes with
//          optional CPSR<-SPSR restore, exception entry request, pc/cpsr/busy status
module arm7_regfile
    import arm7_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] RESET_CPSR = RESET_CPSR_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    arm7_regfile_if.slave  bus
);

    logic [31:0] gpr_q  [NUM_PHYS];
    logic [31:0] spsr_q [NUM_SPSR];
    logic [31:0] cpsr_q;
    logic [31:0] read_value_q;
    logic        busy_q;
    exc_state_e  state_q;
    logic [4:0]  exc_mode_q;
    logic [31:0] exc_return_q;
    logic [31:0] exc_vector_q;

    logic [4:0]  rd_phys;
    logic [4:0]  wr_phys;
    logic [2:0]  cur_spsr_idx;
    logic        cur_spsr_valid;
    logic [4:0]  exc_phys;
    logic [2:0]  exc_spsr_idx;
    logic        exc_spsr_valid;
    logic [31:0] cpsr_save_d;

    // The read decode's SPSR outputs duplicate the write decode's; left open.
    arm7_reg_index u_rd_index (
        .mode_i       (cpsr_q[CPSR_M_MSB:CPSR_M_LSB]),
        .idx_i        (bus.read_reg),
        .phys_o       (rd_phys),
        .spsr_idx_o   (),
        .spsr_valid_o ()
    );

    arm7_reg_index u_wr_index (
        .mode_i       (cpsr_q[CPSR_M_MSB:CPSR_M_LSB]),
        .idx_i        (bus.write_reg),
        .phys_o       (wr_phys),
        .spsr_idx_o   (cur_spsr_idx),
        .spsr_valid_o (cur_spsr_valid)
    );

    // Exception path always targets R14 of the latched target mode.
    arm7_reg_index u_exc_index (
        .mode_i       (exc_mode_q),
        .idx_i        (4'd14),
        .phys_o       (exc_phys),
        .spsr_idx_o   (exc_spsr_idx),
        .spsr_valid_o (exc_spsr_valid)
    );

    always_comb begin
        cpsr_save_d                          = cpsr_q;
        cpsr_save_d[CPSR_M_MSB:CPSR_M_LSB]   = exc_mode_q;
        cpsr_save_d[CPSR_I]                  = 1'b1;
        if (exc_mode_q == MODE_FIQ) cpsr_save_d[CPSR_F] = 1'b1;
        cpsr_save_d[CPSR_T]                  = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PHYS; i++) begin
                gpr_q[i] <= (i == int'(PHYS_PC)) ? RESET_PC : 32'h0;
            end
            for (int i = 0; i < NUM_SPSR; i++) begin
                spsr_q[i] <= 32'h0;
            end
            cpsr_q       <= RESET_CPSR;
            read_value_q <= 32'h0;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
            exc_mode_q   <= 5'h0;
            exc_return_q <= 32'h0;
            exc_vector_q <= 32'h0;
        end else begin
            // Reads see pre-edge state, so a same-edge write is not forwarded.
            if (bus.read_en) read_value_q <= gpr_q[rd_phys];

            unique case (state_q)
                IDLE: begin
                    if (bus.write_en) begin
                        gpr_q[wr_phys] <= bus.write_value;
                        if (bus.write_restore_from_SPSR && cur_spsr_valid) begin
                            cpsr_q <= spsr_q[cur_spsr_idx];
                        end
                    end
                    if (bus.exc_en) begin
                        exc_mode_q   <= bus.exc_mode;
                        exc_return_q <= bus.exc_return;
                        exc_vector_q <= bus.exc_vector;
                        busy_q       <= 1'b1;
                        state_q      <= SAVE;
                    end
                end
                SAVE: begin
                    if (exc_spsr_valid) spsr_q[exc_spsr_idx] <= cpsr_q;
                    cpsr_q  <= cpsr_save_d;
                    state_q <= LINK;
                end
                LINK: begin
                    gpr_q[exc_phys] <= exc_return_q;
                    gpr_q[PHYS_PC]  <= exc_vector_q;
                    busy_q          <= 1'b0;
                    state_q         <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.read_value = read_value_q;
    assign bus.pc         = gpr_q[PHYS_PC];
    assign bus.cpsr       = cpsr_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_arm7_regfile.sv
// tb/tb_arm7_regfile.sv - self-checking bench for arm7_regfile with a banked reference model
module tb_arm7_regfile;
    import arm7_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    arm7_regfile_if bus ();

    arm7_regfile #(
        .RESET_PC   (32'h0000_0000),
        .RESET_CPSR (32'h0000_00D3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    // Reference model: user bank (R15 = PC at index 15), FIQ R8-R14, and
    // R13/R14 pairs for IRQ, SVC, ABT, UND.
    logic [31:0] m_usr [16];
    logic [31:0] m_fiq [7];
    logic [31:0] m_bnk [4][2];
    logic [31:0] m_spsr [5];
    logic [31:0] m_cpsr;
    logic [31:0] m_read;
    logic        m_busy;
    int          m_phase;
    logic [4:0]  m_emode;
    logic [31:0] m_eret;
    logic [31:0] m_evec;

    function automatic int spsr_key(input logic [4:0] md);
        case (md)
            5'h11:   return 0;
            5'h12:   return 1;
            5'h13:   return 2;
            5'h17:   return 3;
            5'h1B:   return 4;
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] mget(input logic [4:0] md, input int idx);
        int k;
        k = spsr_key(md);
        if (idx == 15)              return m_usr[15];
        if (k == 0 && idx >= 8)     return m_fiq[idx-8];
        if (k > 0 && idx >= 13)     return m_bnk[k-1][idx-13];
        return m_usr[idx];
    endfunction

    function automatic void mset(input logic [4:0] md, input int idx, input logic [31:0] v);
        int k;
        k = spsr_key(md);
        if (idx == 15)              m_usr[15] = v;
        else if (k == 0 && idx >= 8) m_fiq[idx-8] = v;
        else if (k > 0 && idx >= 13) m_bnk[k-1][idx-13] = v;
        else                        m_usr[idx] = v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_usr[i] = 32'h0;
        for (int i = 0; i < 7; i++)  m_fiq[i] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            m_bnk[i][0] = 32'h0;
            m_bnk[i][1] = 32'h0;
        end
        for (int i = 0; i < 5; i++)  m_spsr[i] = 32'h0;
        m_cpsr  = 32'hD3;
        m_read  = 32'h0;
        m_busy  = 1'b0;
        m_phase = 0;
        m_emode = 5'h0;
        m_eret  = 32'h0;
        m_evec  = 32'h0;
    endfunction

    // One clock edge of the architectural behaviour, using the inputs present at the edge.
    function automatic void model_step();
        logic [31:0] nr;
        logic [4:0]  md;
        int          k;
        nr = m_read;
        md = m_cpsr[4:0];
        if (bus.read_en) nr = mget(md, int'(bus.read_reg));
        case (m_phase)
            0: begin
                if (bus.write_en) begin
                    mset(md, int'(bus.write_reg), bus.write_value);
                    k = spsr_key(md);
                    if (bus.write_restore_from_SPSR && k >= 0) m_cpsr = m_spsr[k];
                end
                if (bus.exc_en) begin
                    m_emode = bus.exc_mode;
                    m_eret  = bus.exc_return;
                    m_evec  = bus.exc_vector;
                    m_busy  = 1'b1;
                    m_phase = 1;
                end
            end
            1: begin
                k = spsr_key(m_emode);
                if (k >= 0) m_spsr[k] = m_cpsr;
                m_cpsr[4:0] = m_emode;
                m_cpsr[7]   = 1'b1;
                if (m_emode == 5'h11) m_cpsr[6] = 1'b1;
                m_cpsr[5]   = 1'b0;
                m_phase     = 2;
            end
            default: begin
                mset(m_emode, 14, m_eret);
                m_usr[15] = m_evec;
                m_busy    = 1'b0;
                m_phase   = 0;
            end
        endcase
        m_read = nr;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("pc",         bus.pc,         m_usr[15]);
            chk("cpsr",       bus.cpsr,       m_cpsr);
            chk("busy",       {31'h0, bus.busy}, {31'h0, m_busy});
            chk("read_value", bus.read_value, m_read);
        end
    end

    task automatic idle_in();
        bus.read_en = 1'b0;
        bus.read_reg = 4'h0;
        bus.write_en = 1'b0;
        bus.write_reg = 4'h0;
        bus.write_value = 32'h0;
        bus.write_restore_from_SPSR = 1'b0;
        bus.exc_en = 1'b0;
        bus.exc_mode = 5'h0;
        bus.exc_return = 32'h0;
        bus.exc_vector = 32'h0;
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] r, input logic [31:0] v, input logic rest);
        bus.write_en = 1'b1;
        bus.write_reg = r;
        bus.write_value = v;
        bus.write_restore_from_SPSR = rest;
        cyc();
        idle_in();
    endtask

    task automatic do_read(input logic [3:0] r);
        bus.read_en = 1'b1;
        bus.read_reg = r;
        cyc();
        idle_in();
    endtask

    task automatic do_exc(input logic [4:0] md, input logic [31:0] ret, input logic [31:0] vec);
        bus.exc_en = 1'b1;
        bus.exc_mode = md;
        bus.exc_return = ret;
        bus.exc_vector = vec;
        cyc();
        idle_in();
    endtask

    logic [4:0] mode_tbl [8];

    initial begin
        mode_tbl[0] = 5'h11; mode_tbl[1] = 5'h12; mode_tbl[2] = 5'h13; mode_tbl[3] = 5'h17;
        mode_tbl[4] = 5'h1B; mode_tbl[5] = 5'h10; mode_tbl[6] = 5'h1F; mode_tbl[7] = 5'h00;
        idle_in();
        model_reset();
        rst_n = 1'b0;
        chk_on = 1'b1;
        repeat (3) cyc();
        rst_n = 1'b1;

        // Reset state and PC read
        do_read(4'd15);
        chk("t1_read_pc", bus.read_value, 32'h0);
        chk("t1_cpsr",    bus.cpsr,       32'hD3);
        chk("t1_busy",    {31'h0, bus.busy}, 32'h0);

        // SVC R14 then FIQ entry
        do_write(4'd14, 32'h1234, 1'b0);
        do_exc(5'h11, 32'h100, 32'h1C);
        chk("t2_busy_entry", {31'h0, bus.busy}, 32'h1);
        chk("t2_pc_pending", bus.pc, 32'h0);
        cyc();
        cyc();
        chk("t2_pc",   bus.pc,   32'h1C);
        chk("t2_cpsr", bus.cpsr, 32'hD1);
        chk("t2_busy_done", {31'h0, bus.busy}, 32'h0);
        do_read(4'd14);
        chk("t2_r14_fiq", bus.read_value, 32'h100);

        // FIQ R8 write with restore back to SVC (SPSR_fiq holds D3)
        do_write(4'd8, 32'hAA, 1'b1);
        chk("t3_cpsr_restored", bus.cpsr, 32'hD3);
        do_read(4'd8);
        chk("t3_r8_user", bus.read_value, 32'h0);
        do_read(4'd14);
        chk("t3_r14_svc", bus.read_value, 32'h1234);

        // Same-edge read and write of R3
        do_write(4'd3, 32'h5, 1'b0);
        bus.read_en = 1'b1;
        bus.read_reg = 4'd3;
        do_write(4'd3, 32'h9, 1'b0);
        chk("t4_old_value", bus.read_value, 32'h5);
        do_read(4'd3);
        chk("t4_new_value", bus.read_value, 32'h9);

        // Non-banked target mode 10h: no SPSR write, R14 lands in user bank
        do_exc(5'h10, 32'h55, 32'h80);
        cyc();
        cyc();
        chk("t5_cpsr_usr", bus.cpsr, 32'hD0);
        chk("t5_pc",       bus.pc,   32'h80);
        do_read(4'd14);
        chk("t5_r14_user", bus.read_value, 32'h55);
        do_write(4'd15, 32'h40, 1'b1);
        chk("t5_pc_write", bus.pc,   32'h40);
        chk("t5_cpsr_kept", bus.cpsr, 32'hD0);

        // Asynchronous reset during LINK
        do_exc(5'h13, 32'h77, 32'h8);
        cyc();
        chk("t6_busy_link", {31'h0, bus.busy}, 32'h1);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_pc_reset",   bus.pc,   32'h0);
        chk("t6_cpsr_reset", bus.cpsr, 32'hD3);
        chk("t6_busy_reset", {31'h0, bus.busy}, 32'h0);
        cyc();
        rst_n = 1'b1;
        do_read(4'd14);
        chk("t6_r14_cleared", bus.read_value, 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            idle_in();
            bus.read_en = 1'($urandom_range(0, 1));
            bus.read_reg = 4'($urandom);
            bus.write_en = ($urandom_range(0, 99) < 40);
            bus.write_reg = 4'($urandom);
            bus.write_value = $urandom;
            bus.write_restore_from_SPSR = ($urandom_range(0, 9) == 0);
            bus.exc_en = ($urandom_range(0, 14) == 0);
            bus.exc_mode = mode_tbl[$urandom_range(0, 7)];
            bus.exc_return = $urandom;
            bus.exc_vector = $urandom;
            cyc();
        end
        idle_in();
        cyc();

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
